// File: rtl/cmac_approx_pkg.sv
// Shared definitions for the approximate CMAC datapath: FSM encoding,
// product width and the per-step partial-product shift table.
package cmac_approx_pkg;

  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble-pair weights for steps 0..3: lo*lo, hi*lo, lo*hi, hi*hi
  function automatic logic [3:0] stepShift(input logic [1:0] step);
    case (step)
      2'd0:    return 4'd0;
      2'd1:    return 4'd4;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mult4x4.sv
// Approximate 4x4 unsigned multiplier built from four 2x2 cells; the only
// inexact case is a 2x2 digit pair of (3,3), which yields 7 instead of 9.
module mult4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);

  function automatic logic [2:0] mult2x2(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'd3 && b == 2'd3) return 3'd7;
    return {1'b0, a} * {1'b0, b};
  endfunction

  logic [2:0] w_ll;
  logic [2:0] w_hl;
  logic [2:0] w_lh;
  logic [2:0] w_hh;

  assign w_ll = mult2x2(i_a[1:0], i_b[1:0]);
  assign w_hl = mult2x2(i_a[3:2], i_b[1:0]);
  assign w_lh = mult2x2(i_a[1:0], i_b[3:2]);
  assign w_hh = mult2x2(i_a[3:2], i_b[3:2]);

  // Worst case 7 + 28 + 28 + 112 = 175, so the exact sum fits in 8 bits
  assign o_p = 8'(w_ll) + (8'(w_hl) << 2) + (8'(w_lh) << 2) + (8'(w_hh) << 4);

endmodule

// File: rtl/cmac_mult8_iter.sv
// Iterative 8x8 approximate multiply-accumulate: one mult4x4 is reused over
// four CALC cycles, then the 16-bit product is folded into the accumulator.
module cmac_mult8_iter
  import cmac_approx_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_prod,
  output logic [ACC_W-1:0] out_acc,
  output logic             busy
);

  state_t            r_state;
  state_t            w_stateNext;
  logic [1:0]        r_step;
  logic [7:0]        r_a;
  logic [7:0]        r_b;
  logic              r_accClr;
  logic [PROD_W-1:0] r_prod;
  logic [PROD_W-1:0] r_outProd;
  logic [ACC_W-1:0]  r_acc;

  logic              w_accept;
  logic [3:0]        w_nibA;
  logic [3:0]        w_nibB;
  logic [7:0]        w_pp;
  logic [PROD_W-1:0] w_ppShifted;
  logic [PROD_W-1:0] w_prodNext;

  // Step bit 0 picks the high nibble of a, bit 1 the high nibble of b
  assign w_nibA = r_step[0] ? r_a[7:4] : r_a[3:0];
  assign w_nibB = r_step[1] ? r_b[7:4] : r_b[3:0];

  mult4x4 u_mult4x4 (
    .i_a (w_nibA),
    .i_b (w_nibB),
    .o_p (w_pp)
  );

  assign w_ppShifted = PROD_W'(w_pp) << stepShift(r_step);
  assign w_prodNext  = r_prod + w_ppShifted;
  assign w_accept    = in_valid & in_ready;

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) r_state <= IDLE;
    else                  r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_stateNext = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (r_step == 2'd3) w_stateNext = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // The step counter wraps 3 -> 0 on the cycle that publishes the result
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_step    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_accClr  <= 1'b0;
      r_prod    <= '0;
      r_outProd <= '0;
      r_acc     <= '0;
    end else if (w_accept) begin
      r_a      <= in_a;
      r_b      <= in_b;
      r_accClr <= in_acc_clr;
      r_prod   <= '0;
      r_step   <= '0;
    end else if (r_state == CALC) begin
      r_step <= r_step + 2'd1;
      r_prod <= w_prodNext;
      if (r_step == 2'd3) begin
        r_outProd <= w_prodNext;
        r_acc     <= r_accClr ? ACC_W'(w_prodNext) : r_acc + ACC_W'(w_prodNext);
      end
    end
  end

  assign out_prod = r_outProd;
  assign out_acc  = r_acc;

endmodule

// File: tb/tb_cmac_mult8_iter.sv
// Scoreboard bench for cmac_mult8_iter: a 32-bit accumulator instance for the
// main sequence and a 16-bit instance for the wrap-around sequence.
module tb_cmac_mult8_iter;

  typedef struct {
    logic [15:0] prod;
    logic [31:0] acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        inValid = 1'b0, inReady, inAccClr = 1'b0, outValid, outReady = 1'b1, busy;
  logic [7:0]  inA = '0, inB = '0;
  logic [15:0] outProd;
  logic [31:0] outAcc;

  logic        inValid16 = 1'b0, inReady16, inAccClr16 = 1'b0, outValid16, outReady16 = 1'b1, busy16;
  logic [7:0]  inA16 = '0, inB16 = '0;
  logic [15:0] outProd16;
  logic [15:0] outAcc16;

  exp_t q32[$];
  exp_t q16[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cmac_mult8_iter #(.ACC_W(32)) dut (
    .nvdla_core_clk (clk),      .nvdla_core_rstn (rstn),
    .in_valid       (inValid),  .in_ready        (inReady),
    .in_a           (inA),      .in_b            (inB),
    .in_acc_clr     (inAccClr), .out_valid       (outValid),
    .out_ready      (outReady), .out_prod        (outProd),
    .out_acc        (outAcc),   .busy            (busy)
  );

  cmac_mult8_iter #(.ACC_W(16)) dut16 (
    .nvdla_core_clk (clk),        .nvdla_core_rstn (rstn),
    .in_valid       (inValid16),  .in_ready        (inReady16),
    .in_a           (inA16),      .in_b            (inB16),
    .in_acc_clr     (inAccClr16), .out_valid       (outValid16),
    .out_ready      (outReady16), .out_prod        (outProd16),
    .out_acc        (outAcc16),   .busy            (busy16)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Offer one operation to the selected instance and optionally queue its expected result
  task automatic applyStimulus(input bit sel16, input logic [7:0] a, input logic [7:0] b,
                               input logic clr, input bit push,
                               input logic [15:0] prod, input logic [31:0] acc);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (!(sel16 ? inReady16 : inReady) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("acceptTimeout", 32'd0, 32'd1);
    e.prod = prod;
    e.acc  = acc;
    if (sel16) begin
      inA16 = a; inB16 = b; inAccClr16 = clr; inValid16 = 1'b1;
      if (push) q16.push_back(e);
    end else begin
      inA = a; inB = b; inAccClr = clr; inValid = 1'b1;
      if (push) q32.push_back(e);
    end
    @(posedge clk);
    #1;
    inValid   = 1'b0;
    inValid16 = 1'b0;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((q32.size() != 0 || q16.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) checkOutput("drainTimeout", 32'(q32.size() + q16.size()), 32'd0);
  endtask

  // Monitors sample shortly after the falling edge so stimulus set on that edge is seen
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rstn && outValid && outReady) begin
      if (q32.size() == 0) checkOutput("unexpectedOut32", 32'd1, 32'd0);
      else begin
        e = q32.pop_front();
        checkOutput("prod32", 32'(outProd), 32'(e.prod));
        checkOutput("acc32", outAcc, e.acc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rstn && outValid16 && outReady16) begin
      if (q16.size() == 0) checkOutput("unexpectedOut16", 32'd1, 32'd0);
      else begin
        e = q16.pop_front();
        checkOutput("prod16", 32'(outProd16), 32'(e.prod));
        checkOutput("acc16", 32'(outAcc16), e.acc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int pulses;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady", 32'(inReady), 32'd1);
    checkOutput("rstOutValid", 32'(outValid), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstProd", 32'(outProd), 32'd0);
    checkOutput("rstAcc", outAcc, 32'd0);
    checkOutput("rstAcc16", 32'(outAcc16), 32'd0);
    rstn = 1'b1;

    // 0x12*0x21 = 0x252 with latency measured from the accept edge
    applyStimulus(1'b0, 8'h12, 8'h21, 1'b1, 1'b1, 16'h0252, 32'h0000_0252);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (outValid) begin
        lat = n;
        break;
      end
    end
    checkOutput("latency", 32'(lat), 32'd5);
    applyStimulus(1'b0, 8'h10, 8'h10, 1'b0, 1'b1, 16'h0100, 32'h0000_0352);
    waitDrain();

    // Back-pressure in DONE while a new operand is offered
    outReady = 1'b0;
    applyStimulus(1'b0, 8'h03, 8'h05, 1'b0, 1'b1, 16'h000F, 32'h0000_0361);
    lat = 0;
    while (!outValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("reachDone", 32'(outValid), 32'd1);
    inA = 8'h55; inB = 8'h55; inValid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checkOutput("holdValid", 32'(outValid), 32'd1);
      checkOutput("holdProd", 32'(outProd), 32'h000F);
      checkOutput("holdAcc", outAcc, 32'h0000_0361);
      checkOutput("holdInReady", 32'(inReady), 32'd0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    waitDrain();
    repeat (8) @(negedge clk);
    checkOutput("noStrayOp", 32'(outValid), 32'd0);

    // 16-bit accumulator wraps after eight 0x2000 products
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 8'h80, 8'h40, (i == 0), 1'b1, 16'h2000, 32'((32'h2000 * (i + 1)) & 32'hFFFF));
    waitDrain();

    // Reset during CALC step2, then the all-ones approximate case
    applyStimulus(1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("midRstInReady", 32'(inReady), 32'd1);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstAcc", outAcc, 32'd0);
    rstn = 1'b1;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (outValid) pulses++;
    end
    checkOutput("midRstNoPulse", 32'(pulses), 32'd0);
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1, 16'hC58F, 32'h0000_C58F);
    waitDrain();

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
